ft232h_rx: RTL
==============

# ft232h_rx

Receive engine for the FT232H synchronous 245-FIFO interface: it drains bytes from the FT232H receive buffer (RXF#/OE#/RD#) into the write side of the rx dual-clock FIFO. It runs entirely in the 60 MHz FT232H clock domain. The top level owns the tristate data bus and the tx path, and arbitrates the bus using `tx_req`/`rx_active`. A 2-entry skid buffer absorbs downstream backpressure.

## Interface

**Parameters**
- `USEDW_W`, default 10: width of the FIFO write-side used-word count. FIFO depth is 2^USEDW_W.
- `HEADROOM`, default 4: a read burst is not started, and is terminated, while `fifo_wrusedw >= 2^USEDW_W - HEADROOM`.

**Ports**
- One clock, `clk`; reset `rst_n` is asynchronous and active-low.
- `clk` in 1: FT232H CLKOUT, 60 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `data_in` in 8: FT232H data bus, input side.
- `rxf_n` in 1: FT232H RXF#, low when data is available.
- `oe_n` out 1: FT232H OE#, registered.
- `rd_n` out 1: FT232H RD#, registered.
- `tx_req` in 1: tx engine requests the bus. Has priority over rx.
- `rx_active` out 1: high while not IDLE; the top level gives the bus to rx while this is high.
- `fifo_data` out 8: head byte of the skid buffer.
- `fifo_wrreq` out 1: FIFO write strobe.
- `fifo_wrfull` in 1: FIFO full.
- `fifo_wrusedw` in USEDW_W: FIFO write-side used-word count.
- `rx_overrun` out 1: sticky flag, set when a byte arrives while the skid buffer is full. Cleared only by reset.
- `rx_byte_count` out 32: bytes accepted from the FT232H (see Configuration).

## Operation

- `space_ok` = `~fifo_wrfull & (fifo_wrusedw < 2^USEDW_W - HEADROOM) & (skid count == 0)`.
- **IDLE**: `oe_n`=1, `rd_n`=1.
  - Goes to TURN when `~rxf_n & ~tx_req & space_ok`.
  - If `tx_req` and `~rxf_n` are both true, it stays in IDLE (tx wins).
- **TURN**: `oe_n`=0, `rd_n`=1. This is one bus-turnaround cycle. Always goes to READ.
- **READ**: `oe_n`=0, `rd_n`=0.
  - Goes to IDLE when `rxf_n | tx_req | ~space_ok'`.
  - `space_ok'` uses the same FIFO terms as `space_ok` but allows skid count ≤ 1.
- `oe_n` and `rd_n` are registered encodings of the next state. They change on the same edge as the state.
- **Capture**: on every edge where the registered `rd_n`==0 and `rxf_n`==0, `data_in` is pushed into the skid buffer.
  - If the skid buffer is full, the byte is dropped and `rx_overrun` is set.
- **Drain**:
  - `fifo_wrreq = (skid count != 0) & ~fifo_wrfull`.
  - `fifo_data` is the oldest skid entry.
  - At most one byte is popped per cycle.
  - A push and a pop in the same cycle leave the count unchanged and preserve order.
- `rx_active` = (state != IDLE), registered with the state.

## Timing

- **Reset values**: state IDLE, `oe_n`=1, `rd_n`=1, `rx_active`=0, skid empty (`fifo_wrreq`=0, `fifo_data`=0), `rx_overrun`=0, `rx_byte_count`=0.
- **Reset mid-burst**: `oe_n` and `rd_n` go high asynchronously and skid contents are discarded.
- **Burst start**: edge N samples `rxf_n`=0 in IDLE. Then:
  - `oe_n` goes low after N.
  - `rd_n` goes low after N+1.
  - The first capture happens at N+2.
  - The first FIFO write happens at N+3.
- **Steady state**: one byte per clock.
- **End on `rxf_n`**: edge M in READ samples `rxf_n`=1. There is no capture at M, and `oe_n`/`rd_n` are high after M.
- **End on `tx_req` or headroom** (with `rxf_n`=0): the byte at M is captured, and `oe_n`/`rd_n` are high after M. No further bytes are read.
- **Minimum gap**: there is at least one IDLE cycle between bursts.
- **Downstream stall**: `fifo_wrfull` high stalls the drain with no loss of data.

## Configuration

- `FT232H_RX_COUNT_EN` defined:
  - `rx_byte_count` increments by 1 on every capture edge, including dropped bytes.
  - It wraps modulo 2^32.
- `FT232H_RX_COUNT_EN` not defined: `rx_byte_count` is tied to 0 and no counter logic is generated.

## Test plan

- **Burst**: `rxf_n` low for 5 bytes 0x11..0x15, FIFO empty.
  - `oe_n` falls exactly one clock before `rd_n`.
  - FIFO receives 0x11..0x15 in order, first write 3 edges after `rxf_n` is sampled low.
  - With the macro defined, `rx_byte_count`=5.
- **`rxf_n` high mid-burst**: `rxf_n` rises after byte 3.
  - Exactly 3 bytes are written.
  - `rd_n`/`oe_n` are high after the sampling edge.
  - When `rxf_n` falls again, the remaining bytes follow after IDLE→TURN.
- **Headroom**: `fifo_wrusedw`=1020 (USEDW_W=10, HEADROOM=4) with `rxf_n` low.
  - Stays in IDLE with `oe_n`=1.
  - When `fifo_wrusedw` drops to 1019, TURN follows on the next edge.
- **`tx_req` priority**:
  - `tx_req` asserted during READ: one more byte is captured, then IDLE with `rx_active`=0.
  - `tx_req` and `~rxf_n` together in IDLE: no TURN.
- **Backpressure**: `fifo_wrfull` held high for 4 cycles mid-burst.
  - The burst terminates.
  - Bytes are held in the skid buffer and written in order once full deasserts.
  - `rx_overrun` stays 0.
- **Reset mid-burst**: `rst_n` low during READ.
  - `oe_n`/`rd_n`=1 immediately.
  - `fifo_wrreq`=0, and `rx_byte_count`=0.

Source files
------------

// File: rtl/ft232h_rx.sv
// ---------------------------------------------------------------------------
// ft232h_rx
//
// Receive engine for the FT232H synchronous 245-FIFO interface. Bytes are
// drained from the FT232H receive buffer (RXF#/OE#/RD#) into the write side of
// the rx dual-clock FIFO. Everything runs in the 60 MHz FT232H CLKOUT domain.
// The top level owns the tristate bus and the tx path; it hands the bus to
// this block while rx_active is high. tx_req always has priority over rx.
//
// A 2-entry skid buffer sits between the FT232H bus and the FIFO write port.
// It absorbs the byte that is already in flight when the FIFO stalls.
//
// Handshake: the FIFO write side is a plain strobe interface. A byte is
// transferred on every rising clk edge where fifo_wrreq is high. fifo_wrreq
// is only raised while fifo_wrfull is low, so no accepted byte is ever lost.
//
// FSM state is visible on the ports: (oe_n, rd_n) = 11 IDLE, 01 TURN,
// 00 READ, and rx_active is high outside IDLE.
//
// Optional feature (macro FT232H_RX_COUNT_EN):
//   defined     -> rx_byte_count counts capture edges (incl. dropped bytes),
//                  wrapping modulo 2^32
//   not defined -> rx_byte_count is tied to zero, no counter logic
//
// Ports
//   clk           in   FT232H CLKOUT (60 MHz)
//   rst_n         in   asynchronous active-low reset
//   data_in       in   FT232H data bus, input side
//   rxf_n         in   FT232H RXF#, low when data is available
//   oe_n          out  FT232H OE#, registered
//   rd_n          out  FT232H RD#, registered
//   tx_req        in   tx engine requests the bus (wins over rx)
//   rx_active     out  high while the engine is not IDLE
//   fifo_data     out  oldest skid buffer byte
//   fifo_wrreq    out  FIFO write strobe
//   fifo_wrfull   in   FIFO full
//   fifo_wrusedw  in   FIFO write-side used-word count
//   rx_overrun    out  sticky: byte arrived while the skid buffer was full
//   rx_byte_count out  bytes taken from the FT232H
// ---------------------------------------------------------------------------
module ft232h_rx #(
    parameter int USEDW_W  = 10,
    parameter int HEADROOM = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         data_in,
    input  logic               rxf_n,
    output logic               oe_n,
    output logic               rd_n,
    input  logic               tx_req,
    output logic               rx_active,
    output logic [7:0]         fifo_data,
    output logic               fifo_wrreq,
    input  logic               fifo_wrfull,
    input  logic [USEDW_W-1:0] fifo_wrusedw,
    output logic               rx_overrun,
    output logic [31:0]        rx_byte_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_READ = 2'd2
    } state_t;

    // Used-word level at which bursts are refused or cut short.
    localparam logic [USEDW_W:0] USEDW_LIMIT =
        (USEDW_W+1)'((1 << USEDW_W) - HEADROOM);

    state_t      state;
    state_t      state_nxt;
    logic        oe_n_nxt;
    logic        rd_n_nxt;
    logic        rx_active_nxt;

    logic [1:0]  skid_cnt;
    logic [7:0]  skid0;         // oldest entry
    logic [7:0]  skid1;
    logic        fifo_room;
    logic        space_ok;
    logic        space_ok_rd;
    logic        capture;
    logic        skid_full;
    logic        push;
    logic        pop;

    assign fifo_room   = ~fifo_wrfull & ({1'b0, fifo_wrusedw} < USEDW_LIMIT);
    // Starting a burst needs an empty skid; continuing tolerates one entry,
    // which leaves a slot for the byte already committed by the low RD#.
    assign space_ok    = fifo_room & (skid_cnt == 2'd0);
    assign space_ok_rd = fifo_room & ~skid_cnt[1];

    // RD# was low during the cycle, so the FT232H drives a valid byte now.
    assign capture   = ~rd_n & ~rxf_n;
    assign skid_full = (skid_cnt == 2'd2);
    assign push      = capture & ~skid_full;
    assign pop       = fifo_wrreq;

    assign fifo_wrreq = (skid_cnt != 2'd0) & ~fifo_wrfull;
    assign fifo_data  = skid0;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            oe_n      <= 1'b1;
            rd_n      <= 1'b1;
            rx_active <= 1'b0;
        end else begin
            state     <= state_nxt;
            oe_n      <= oe_n_nxt;
            rd_n      <= rd_n_nxt;
            rx_active <= rx_active_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (~rxf_n & ~tx_req & space_ok) state_nxt = ST_TURN;
            ST_TURN: state_nxt = ST_READ;
            ST_READ: if (rxf_n | tx_req | ~space_ok_rd) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (encoded from next state) ----------------
    always_comb begin
        oe_n_nxt      = 1'b1;
        rd_n_nxt      = 1'b1;
        rx_active_nxt = (state_nxt != ST_IDLE);
        case (state_nxt)
            ST_TURN: oe_n_nxt = 1'b0;
            ST_READ: begin
                oe_n_nxt = 1'b0;
                rd_n_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // ---------------- skid buffer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_cnt <= 2'd0;
            skid0    <= 8'h00;
            skid1    <= 8'h00;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) skid0 <= data_in;
                    else                  skid1 <= data_in;
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new byte queues behind the rest.
                    if (skid_cnt == 2'd1) begin
                        skid0 <= data_in;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= data_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    rx_overrun <= 1'b0;
        else if (capture & skid_full)  rx_overrun <= 1'b1;
    end

`ifdef FT232H_RX_COUNT_EN
    logic [31:0] byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       byte_cnt <= 32'd0;
        else if (capture) byte_cnt <= byte_cnt + 32'd1;
    end

    assign rx_byte_count = byte_cnt;
`else
    assign rx_byte_count = 32'd0;
`endif

endmodule
